// File: rtl/systolic_array_n.sv
// systolic_array_n: N x N weight-stationary systolic array with
// double-buffered weights and a fixed 2N-cycle result latency.
module systolic_array_n #(
    parameter int N  = 4,
    parameter int DW = 16,
    parameter int AW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            w_valid,
    output logic            w_ready,
    input  logic [N*DW-1:0] w_data,
    input  logic            sw_req,
    output logic            sw_ack,
    output logic            sw_err,
    input  logic            x_valid,
    output logic            x_ready,
    input  logic [N*DW-1:0] x_data,
    output logic            y_valid,
    output logic [N*AW-1:0] y_data,
    output logic            w_full,
    output logic            act_valid,
    output logic            busy
);
    localparam int RW = $clog2(N + 1);
    localparam int CW = $clog2(2 * N + 2);
    localparam int PW = 2 * DW;

    typedef enum logic {IDLE, PEND} state_t;
    state_t state, state_n;

    logic signed [DW-1:0] shadow [N][N];
    logic signed [DW-1:0] active [N][N];
    logic [RW-1:0] row_cnt;
    logic [CW-1:0] cnt;
    logic [2*N-1:0] vp;
    logic accept, w_fire;

    logic signed [DW-1:0] xq  [N];
    logic signed [DW-1:0] xsk [N];
    logic signed [DW-1:0] xin [N][N];
    logic signed [DW-1:0] xr  [N][N-1];
    logic signed [PW-1:0] prod [N][N];
    logic signed [AW-1:0] pin [N][N];
    logic signed [AW-1:0] ps  [N][N];
    logic signed [AW-1:0] dsk [N];

    assign w_full  = row_cnt == RW'(N);
    assign w_ready = !w_full;
    assign w_fire  = w_valid && w_ready;
    assign x_ready = act_valid && state == IDLE;
    assign accept  = x_valid && x_ready;
    assign busy    = cnt != '0;

    always_comb begin
        state_n = state;
        sw_ack  = 1'b0;
        unique case (state)
            IDLE: if (sw_req && w_full) state_n = PEND;
            PEND: begin
                if (cnt == '0) begin
                    sw_ack  = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            sw_err <= 1'b0;
            cnt    <= '0;
            vp     <= '0;
        end else begin
            state  <= state_n;
            sw_err <= state == IDLE && sw_req && !w_full;
            cnt    <= cnt + CW'(accept) - CW'(y_valid);
            vp     <= {vp[2*N-2:0], accept};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    shadow[r][c] <= '0;
                    active[r][c] <= '0;
                end
            end
            row_cnt   <= '0;
            act_valid <= 1'b0;
        end else if (sw_ack) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    active[r][c] <= shadow[r][c];
                end
            end
            row_cnt   <= '0;
            act_valid <= 1'b1;
        end else if (w_fire) begin
            for (int r = 0; r < N; r++) begin
                if (row_cnt == RW'(r)) begin
                    for (int c = 0; c < N; c++) begin
                        shadow[r][c] <= w_data[c*DW +: DW];
                    end
                end
            end
            row_cnt <= row_cnt + 1'b1;
        end
    end

    // Idle cycles feed zeros so stale lanes never carry old operands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) xq[i] <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                xq[i] <= accept ? x_data[i*DW +: DW] : '0;
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_skew
        if (i == 0) begin : g_none
            assign xsk[i] = xq[i];
        end else begin : g_dly
            logic signed [DW-1:0] d [i];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < i; k++) d[k] <= '0;
                end else begin
                    d[0] <= xq[i];
                    for (int k = 1; k < i; k++) d[k] <= d[k-1];
                end
            end
            assign xsk[i] = d[i-1];
        end
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            xin[i][0] = xsk[i];
            for (int j = 1; j < N; j++) xin[i][j] = xr[i][j-1];
        end
        for (int j = 0; j < N; j++) begin
            pin[0][j] = '0;
            for (int i = 1; i < N; i++) pin[i][j] = ps[i-1][j];
        end
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                prod[i][j] = PW'(xin[i][j]) * PW'(active[i][j]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) ps[i][j] <= '0;
                for (int j = 0; j < N - 1; j++) xr[i][j] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++) begin
                    ps[i][j] <= pin[i][j] + AW'(prod[i][j]);
                end
                for (int j = 0; j < N - 1; j++) xr[i][j] <= xin[i][j];
            end
        end
    end

    for (genvar j = 0; j < N; j++) begin : g_deskew
        if (j == N - 1) begin : g_none
            assign dsk[j] = ps[N-1][j];
        end else begin : g_dly
            logic signed [AW-1:0] d [N-1-j];
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    for (int k = 0; k < N - 1 - j; k++) d[k] <= '0;
                end else begin
                    d[0] <= ps[N-1][j];
                    for (int k = 1; k < N - 1 - j; k++) d[k] <= d[k-1];
                end
            end
            assign dsk[j] = d[N-2-j];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            y_valid <= 1'b0;
            y_data  <= '0;
        end else begin
            y_valid <= vp[2*N-1];
            if (vp[2*N-1]) begin
                for (int j = 0; j < N; j++) y_data[j*AW +: AW] <= dsk[j];
            end
        end
    end
endmodule

// File: tb/tb_systolic_array_n.sv
// tb_systolic_array_n: scenario tasks plus a matrix-vector
// reference model for the 2x2 systolic array.
module tb_systolic_array_n;
    localparam int N  = 2;
    localparam int DW = 16;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic w_valid = 1'b0, sw_req = 1'b0, x_valid = 1'b0;
    logic [N*DW-1:0] w_data = '0, x_data = '0;
    logic w_ready, sw_ack, sw_err, x_ready, y_valid;
    logic w_full, act_valid, busy;
    logic [N*AW-1:0] y_data;

    systolic_array_n #(.N(N), .DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .sw_req(sw_req), .sw_ack(sw_ack), .sw_err(sw_err),
        .x_valid(x_valid), .x_ready(x_ready), .x_data(x_data),
        .y_valid(y_valid), .y_data(y_data),
        .w_full(w_full), .act_valid(act_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int c;
        logic [N*AW-1:0] y;
    } ev_t;

    ev_t exp_q[$], got_q[$];
    ev_t ev_a, ev_b;
    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;
    int shd_m [N][N];
    int act_m [N][N];
    int ld_row = 0;

    function automatic logic [N*AW-1:0] model_y(input logic [N*DW-1:0] x);
        logic [N*AW-1:0] y;
        longint s;
        y = '0;
        for (int j = 0; j < N; j++) begin
            s = 0;
            for (int i = 0; i < N; i++) begin
                s += longint'($signed(x[i*DW +: DW])) * longint'(act_m[i][j]);
            end
            y[j*AW +: AW] = s[AW-1:0];
        end
        return y;
    endfunction

    function automatic void model_load(input logic [N*DW-1:0] d);
        if (ld_row < N) begin
            for (int j = 0; j < N; j++) shd_m[ld_row][j] = $signed(d[j*DW +: DW]);
            ld_row++;
        end
    endfunction

    function automatic void model_switch();
        if (ld_row == N) begin
            act_m = shd_m;
            ld_row = 0;
        end
    endfunction

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst && x_valid && x_ready) begin
            ev_a.c = cyc + 2 * N;
            ev_a.y = model_y(x_data);
            exp_q.push_back(ev_a);
        end
    end

    always @(negedge clk) begin
        if (y_valid) begin
            ev_b.c = cyc;
            ev_b.y = y_data;
            got_q.push_back(ev_b);
        end
    end

    task automatic load_row(input logic [N*DW-1:0] d);
        w_valid = 1'b1;
        w_data = d;
        model_load(d);
        @(negedge clk);
        w_valid = 1'b0;
    endtask

    task automatic send_x(input logic [N*DW-1:0] d);
        x_valid = 1'b1;
        x_data = d;
        @(negedge clk);
        x_valid = 1'b0;
    endtask

    task automatic do_switch();
        sw_req = 1'b1;
        @(negedge clk);
        sw_req = 1'b0;
        repeat (2) @(negedge clk);
        model_switch();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({w_ready, x_ready, busy, y_valid, w_full, act_valid, sw_ack, sw_err} !== 8'b1000_0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 10000000",
                     {w_ready, x_ready, busy, y_valid, w_full, act_valid, sw_ack, sw_err});
        end
        n_cmp++;
        if (y_data !== '0) begin
            n_fail++;
            $display("FAIL reset_ydata: got %h want 0", y_data);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (x_ready !== 1'b0 || w_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL post_reset: x_ready %b w_ready %b want 0 1", x_ready, w_ready);
        end
    endtask

    task automatic test_basic();
        int e;
        load_row({16'd2, 16'd1});
        n_cmp++;
        if (w_full !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_not_full: got %b want 0", w_full);
        end
        load_row({16'd4, 16'd3});
        n_cmp++;
        if (w_full !== 1'b1 || w_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_full: w_full %b w_ready %b want 1 0", w_full, w_ready);
        end
        sw_req = 1'b1;
        @(negedge clk);
        sw_req = 1'b0;
        n_cmp++;
        if (sw_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_sw_ack: got %b want 1", sw_ack);
        end
        model_switch();
        @(negedge clk);
        n_cmp++;
        if ({act_valid, sw_ack, w_full} !== 3'b100) begin
            n_fail++;
            $display("FAIL basic_after_sw: got %b want 100", {act_valid, sw_ack, w_full});
        end
        e = cyc + 1;
        send_x({16'd6, 16'd5});
        repeat (2 * N + 3) @(negedge clk);
        n_cmp++;
        if (got_q.size() != 1 || got_q[0].c != e + 2 * N || got_q[0].y !== {32'd34, 32'd23}) begin
            n_fail++;
            $display("FAIL basic_y: got n=%0d cyc %0d y %h want n=1 cyc %0d y %h",
                     got_q.size(), got_q.size() > 0 ? got_q[0].c : -1,
                     got_q.size() > 0 ? got_q[0].y : '0, e + 2 * N, {32'd34, 32'd23});
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_back_to_back();
        int e;
        e = cyc + 1;
        x_valid = 1'b1;
        x_data = {16'd2, 16'hFFFF};
        @(negedge clk);
        x_data = {16'd0, 16'd7};
        @(negedge clk);
        x_valid = 1'b0;
        repeat (2 * N + 3) @(negedge clk);
        n_cmp++;
        if (got_q.size() != 2) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d want 2", got_q.size());
        end else begin
            n_cmp++;
            if (got_q[0].c != e + 2 * N || got_q[0].y !== {32'd6, 32'd5}) begin
                n_fail++;
                $display("FAIL b2b_y0: got cyc %0d y %h want cyc %0d y %h",
                         got_q[0].c, got_q[0].y, e + 2 * N, {32'd6, 32'd5});
            end
            n_cmp++;
            if (got_q[1].c != e + 2 * N + 1 || got_q[1].y !== {32'd14, 32'd7}) begin
                n_fail++;
                $display("FAIL b2b_y1: got cyc %0d y %h want cyc %0d y %h",
                         got_q[1].c, got_q[1].y, e + 2 * N + 1, {32'd14, 32'd7});
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_drain();
        int e3, bad, last_y, ack;
        logic [N*DW-1:0] d;
        for (int k = 0; k < 3; k++) begin
            x_valid = 1'b1;
            x_data = $urandom;
            w_valid = k < 2;
            if (k < 2) begin
                d = $urandom;
                w_data = d;
                model_load(d);
            end
            sw_req = k == 2;
            e3 = cyc + 1;
            @(negedge clk);
        end
        x_valid = 1'b0;
        w_valid = 1'b0;
        sw_req = 1'b0;
        bad = 0;
        last_y = -1;
        ack = -1;
        for (int t = 0; t < 20 && ack < 0; t++) begin
            if (x_ready !== 1'b0) bad++;
            if (y_valid === 1'b1) last_y = cyc;
            if (sw_ack === 1'b1) ack = cyc;
            else @(negedge clk);
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL drain_x_ready: x_ready high %0d cycles want 0", bad);
        end
        n_cmp++;
        if (last_y != e3 + 2 * N || ack != e3 + 2 * N + 1) begin
            n_fail++;
            $display("FAIL drain_ack: last_y %0d ack %0d want %0d %0d",
                     last_y, ack, e3 + 2 * N, e3 + 2 * N + 1);
        end
        model_switch();
        @(negedge clk);
        n_cmp++;
        if (act_valid !== 1'b1 || w_full !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drain_after: act %b full %b busy %b want 1 0 0",
                     act_valid, w_full, busy);
        end
        x_valid = 1'b1;
        repeat (2) begin
            x_data = $urandom;
            @(negedge clk);
        end
        x_valid = 1'b0;
        repeat (2 * N + 3) @(negedge clk);
        n_cmp++;
        if (got_q.size() != 5 || exp_q.size() != 5) begin
            n_fail++;
            $display("FAIL drain_count: got %0d exp %0d want 5", got_q.size(), exp_q.size());
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_cmp++;
            if (got_q[k].c != exp_q[k].c || got_q[k].y !== exp_q[k].y) begin
                n_fail++;
                $display("FAIL drain_y[%0d]: got cyc %0d y %h want cyc %0d y %h",
                         k, got_q[k].c, got_q[k].y, exp_q[k].c, exp_q[k].y);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reject();
        load_row({2{16'h7FFF}});
        sw_req = 1'b1;
        @(negedge clk);
        sw_req = 1'b0;
        n_cmp++;
        if (sw_err !== 1'b1 || sw_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reject_err: sw_err %b sw_ack %b want 1 0", sw_err, sw_ack);
        end
        @(negedge clk);
        n_cmp++;
        if ({sw_err, sw_ack, act_valid, x_ready} !== 4'b0011) begin
            n_fail++;
            $display("FAIL reject_after: got %b want 0011",
                     {sw_err, sw_ack, act_valid, x_ready});
        end
    endtask

    task automatic test_full_wrap();
        int e, bad;
        load_row({2{16'h7FFF}});
        n_cmp++;
        if (w_full !== 1'b1 || w_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_flags: w_full %b w_ready %b want 1 0", w_full, w_ready);
        end
        bad = 0;
        w_valid = 1'b1;
        w_data = '0;
        repeat (3) begin
            @(negedge clk);
            if (w_ready !== 1'b0) bad++;
        end
        w_valid = 1'b0;
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL full_hold: w_ready high %0d cycles want 0", bad);
        end
        do_switch();
        e = cyc + 1;
        send_x({2{16'h7FFF}});
        repeat (2 * N + 3) @(negedge clk);
        n_cmp++;
        if (got_q.size() != 1 || got_q[0].c != e + 2 * N || got_q[0].y !== {2{32'd2147352578}}) begin
            n_fail++;
            $display("FAIL full_max_y: got n=%0d y %h want n=1 y %h at %0d",
                     got_q.size(), got_q.size() > 0 ? got_q[0].y : '0,
                     {2{32'd2147352578}}, e + 2 * N);
        end
        exp_q.delete();
        got_q.delete();
        load_row({2{16'h8000}});
        load_row({2{16'h8000}});
        do_switch();
        send_x({2{16'h8000}});
        repeat (2 * N + 3) @(negedge clk);
        n_cmp++;
        if (got_q.size() != 1 || got_q[0].y !== {2{32'h8000_0000}}) begin
            n_fail++;
            $display("FAIL wrap_y: got n=%0d y %h want n=1 y %h", got_q.size(),
                     got_q.size() > 0 ? got_q[0].y : '0, {2{32'h8000_0000}});
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_random();
        int sent;
        for (int r = 0; r < N; r++) load_row($urandom);
        do_switch();
        sent = 0;
        for (int t = 0; t < 60; t++) begin
            x_valid = $urandom_range(0, 1) == 1;
            x_data = $urandom;
            if (x_valid) sent++;
            @(negedge clk);
        end
        x_valid = 1'b0;
        repeat (2 * N + 3) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != sent || got_q.size() != sent) begin
            n_fail++;
            $display("FAIL rand_count: exp %0d got %0d want %0d",
                     exp_q.size(), got_q.size(), sent);
        end
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
            n_cmp++;
            if (got_q[k].c != exp_q[k].c || got_q[k].y !== exp_q[k].y) begin
                n_fail++;
                $display("FAIL rand_y[%0d]: got cyc %0d y %h want cyc %0d y %h",
                         k, got_q[k].c, got_q[k].y, exp_q[k].c, exp_q[k].y);
            end
        end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset_mid();
        x_valid = 1'b1;
        repeat (2) begin
            x_data = $urandom;
            @(negedge clk);
        end
        x_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({act_valid, x_ready, busy, y_valid} !== 4'b0000) begin
            n_fail++;
            $display("FAIL rst_mid_flags: got %b want 0000",
                     {act_valid, x_ready, busy, y_valid});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                act_m[i][j] = 0;
                shd_m[i][j] = 0;
            end
        end
        ld_row = 0;
        repeat (10) @(negedge clk);
        n_cmp++;
        if (got_q.size() != 0 || x_ready !== 1'b0 || act_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_after: y count %0d x_ready %b act %b want 0 0 0",
                     got_q.size(), x_ready, act_valid);
        end
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                act_m[i][j] = 0;
                shd_m[i][j] = 0;
            end
        end
        test_reset();
        test_basic();
        test_back_to_back();
        test_drain();
        test_reject();
        test_full_wrap();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
